memory_cycle: RTL

Memory (M) stage of the 5-stage RV32I pipeline. It sits directly downstream of the execute stage and consumes its M-side outputs. It holds the word-addressed data memory and performs stores and loads with a configurable number of wait states. It drives StallM to the hazard unit while an access is pending and registers the write-back (W) stage signals.

---
 rtl/memory_cycle.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/memory_cycle.sv
// ============================================================================
//  Module   : memory_cycle
//  Purpose  : Memory (M) stage of a 5-stage RV32I pipeline. Holds the
//             word-addressed data memory, performs loads/stores with a
//             configurable number of wait states, drives StallM to the hazard
//             unit and registers the write-back (W) stage signals.
//  Options  : MEM_MISALIGN_CHECK_EN - adds MisalignM output; misaligned
//             stores are dropped and misaligned loads return a bubble.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_cycle #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic        MisalignM,
`endif
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        StallM
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam bit         c_has_wait = (WAIT_STATES != 0);
  localparam logic [3:0] c_cnt_init = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  // Data memory: never reset, contents survive rst
  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        regwrite_w_q, regwrite_w_d;
  logic        resultsrc_w_q, resultsrc_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] pcplus4_w_q, pcplus4_w_d;
  logic [31:0] aluresult_w_q, aluresult_w_d;
  logic [31:0] readdata_w_q, readdata_w_d;

  logic              w_access;
  logic              w_misalign;
  logic              w_stall_fsm;
  logic              w_stall;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rdata;

  assign w_access = MemWriteM | ResultSrcM;
  // Byte offset and upper bits dropped: the address wraps modulo DEPTH words
  assign w_addr   = ALU_ResultM[ADDR_W+1:2];
  assign w_rdata  = mem[w_addr];

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = w_access & (ALU_ResultM[1:0] != 2'b00);
  assign MisalignM  = w_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  // Stall is forced low while reset is asserted so the hazard unit sees the
  // pipeline released immediately, even mid-access
  assign w_stall  = w_stall_fsm & rst;
  assign StallM   = w_stall;

  // Stores commit only on the completing cycle; an aborted store is dropped
  assign w_mem_we = MemWriteM & ~w_stall & rst & ~w_misalign;

  // Wait-state sequencing: stall for WAIT_STATES cycles, then complete
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_stall_fsm = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_access && c_has_wait) begin
          w_stall_fsm = 1'b1;
          state_d     = ST_WAIT;
          cnt_d       = c_cnt_init;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          w_stall_fsm = 1'b1;
          cnt_d       = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // W-stage next values: bubble while stalled, otherwise capture the M stage
  always_comb begin
    regwrite_w_d  = regwrite_w_q;
    resultsrc_w_d = resultsrc_w_q;
    rd_w_d        = rd_w_q;
    pcplus4_w_d   = pcplus4_w_q;
    aluresult_w_d = aluresult_w_q;
    readdata_w_d  = readdata_w_q;
    if (w_stall) begin
      regwrite_w_d  = 1'b0;
      resultsrc_w_d = 1'b0;
    end else begin
      regwrite_w_d  = RegWriteM;
      resultsrc_w_d = ResultSrcM;
      rd_w_d        = RD_M;
      pcplus4_w_d   = PCPlus4M;
      aluresult_w_d = ALU_ResultM;
      readdata_w_d  = w_rdata;
      // A misaligned load is squashed rather than returning the aligned word
      if (w_misalign && ResultSrcM) begin
        regwrite_w_d = 1'b0;
        readdata_w_d = 32'd0;
      end
    end
  end

  // FSM and W-stage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= 1'b0;
      rd_w_q        <= 5'd0;
      pcplus4_w_q   <= 32'd0;
      aluresult_w_q <= 32'd0;
      readdata_w_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      regwrite_w_q  <= regwrite_w_d;
      resultsrc_w_q <= resultsrc_w_d;
      rd_w_q        <= rd_w_d;
      pcplus4_w_q   <= pcplus4_w_d;
      aluresult_w_q <= aluresult_w_d;
      readdata_w_q  <= readdata_w_d;
    end
  end

  // Memory write port; the read above sees the pre-write contents this cycle
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_addr] <= WriteDataM;
    end
  end

  assign RegWriteW   = regwrite_w_q;
  assign ResultSrcW  = resultsrc_w_q;
  assign RD_W        = rd_w_q;
  assign PCPlus4W    = pcplus4_w_q;
  assign ALU_ResultW = aluresult_w_q;
  assign ReadDataW   = readdata_w_q;

endmodule

`default_nettype wire
